qsys_system_dac_div_bank: RTL and testbench

Parametrised multi-channel DAC update-rate divider bank on an Avalon-MM slave. Each channel holds a double-buffered divider value and a down-counter that emits a one-cycle `tick` clock-enable every (div+1) cycles to pace its DAC. Channel dividers are staged in shadow registers and committed together, phase-aligned to channel 0, so lock-in reference DACs retune without relative phase slip.

---
 rtl/qsys_system_dac_div_bank.sv | 130 +++++++++++++
 tb/tb_qsys_system_dac_div_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_system_dac_div_bank.sv
// Multi-channel DAC update-rate divider bank behind an Avalon-MM slave.
// Shadow dividers are committed together, phase-aligned to channel 0's tick.
module qsys_system_dac_div_bank #(
    parameter int NUM_CH = 8,
    parameter int DIV_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [NUM_CH*DIV_W-1:0] div_out,
    output logic [NUM_CH-1:0]       tick
);

    localparam logic [4:0]  ADDR_ENABLE = 5'd16;
    localparam logic [4:0]  ADDR_COMMIT = 5'd17;
    localparam logic [4:0]  ADDR_STICKY = 5'd18;
    localparam logic [4:0]  ADDR_ID     = 5'd19;
    localparam logic [31:0] ID_WORD     = {16'b0, 8'(NUM_CH), 8'(DIV_W)};

    logic [DIV_W-1:0]  shadow [NUM_CH];
    logic [DIV_W-1:0]  active [NUM_CH];
    logic [DIV_W-1:0]  cnt    [NUM_CH];
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] sticky;
    logic              pending;

    logic wr;
    logic wr_enable;
    logic wr_commit;
    logic wr_sticky;
    logic commit_now;
    logic unused_wdata;

    assign wr        = chipselect && !write_n;
    assign wr_enable = wr && (address == ADDR_ENABLE);
    assign wr_commit = wr && (address == ADDR_COMMIT) && writedata[0];
    assign wr_sticky = wr && (address == ADDR_STICKY);

    // With channel 0 running, the commit waits for its reload edge so every
    // channel restarts in phase with it; otherwise it lands on the next edge.
    assign commit_now = pending && (!enable[0] || (cnt[0] == '0));

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                cnt[i]    <= '0;
            end
            tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr && (address == 5'(i))) begin
                    shadow[i] <= writedata[DIV_W-1:0];
                end
                if (commit_now) begin
                    active[i] <= shadow[i];
                end
                // Tick comes from the old count even on a commit edge; the
                // commit only overrides what the counter loads next.
                if (!enable[i]) begin
                    cnt[i]  <= active[i];
                    tick[i] <= 1'b0;
                end else begin
                    tick[i] <= (cnt[i] == '0);
                    if (commit_now) begin
                        cnt[i] <= shadow[i];
                    end else if (cnt[i] == '0) begin
                        cnt[i] <= active[i];
                    end else begin
                        cnt[i] <= cnt[i] - DIV_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable  <= '0;
            pending <= 1'b0;
            sticky  <= '0;
        end else begin
            if (wr_enable) begin
                enable <= writedata[NUM_CH-1:0];
            end
            // A fresh commit request on the commit edge keeps pending armed.
            if (wr_commit) begin
                pending <= 1'b1;
            end else if (commit_now) begin
                pending <= 1'b0;
            end
            if (wr_sticky) begin
                sticky <= (sticky & ~writedata[NUM_CH-1:0]) | tick;
            end else begin
                sticky <= sticky | tick;
            end
        end
    end

    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == 5'(i)) begin
                readdata[DIV_W-1:0] = shadow[i];
            end
        end
        case (address)
            ADDR_ENABLE: readdata[NUM_CH-1:0] = enable;
            ADDR_COMMIT: readdata[0]          = pending;
            ADDR_STICKY: readdata[NUM_CH-1:0] = sticky;
            ADDR_ID:     readdata             = ID_WORD;
            default:     ;
        endcase
    end

    always_comb begin
        div_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_out[i*DIV_W +: DIV_W] = active[i];
        end
    end

endmodule

// File: tb/tb_qsys_system_dac_div_bank.sv
// Self-checking bench for qsys_system_dac_div_bank: register vectors, directed
// commit/phase sequences and randomized traffic against a tick-schedule model.
module tb_qsys_system_dac_div_bank;

    localparam int NUM_CH = 8;
    localparam int DIV_W  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [63:0] div_out;
    logic [7:0]  tick;

    qsys_system_dac_div_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .div_out(div_out), .tick(tick)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: each enabled channel carries the absolute edge number of its next tick.
    logic [7:0] m_sh [8];
    logic [7:0] m_act [8];
    int         m_due [8];
    logic [7:0] m_en, m_sticky, m_tick;
    logic       m_pend;
    int         edge_n = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            m_sh[i] = '0; m_act[i] = '0; m_due[i] = 0;
        end
        m_en = '0; m_sticky = '0; m_tick = '0; m_pend = 1'b0;
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        logic [31:0] r = '0;
        if (a < 5'd8)        r[7:0] = m_sh[a[2:0]];
        else if (a == 5'd16) r[7:0] = m_en;
        else if (a == 5'd17) r[0]   = m_pend;
        else if (a == 5'd18) r[7:0] = m_sticky;
        else if (a == 5'd19) r      = 32'h0000_0808;
        return r;
    endfunction

    function automatic logic [63:0] modelDiv();
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_act[i];
        return r;
    endfunction

    task automatic modelEdge(input logic w, input logic [4:0] a, input logic [31:0] d);
        int n1 = edge_n + 1;
        logic [7:0] old_tick = m_tick;
        logic cmt = m_pend && (!m_en[0] || (m_due[0] == n1));
        for (int i = 0; i < 8; i++) begin
            if (m_en[i]) begin
                m_tick[i] = (m_due[i] == n1);
                if (cmt)            m_due[i] = n1 + int'(m_sh[i]) + 1;
                else if (m_tick[i]) m_due[i] = n1 + int'(m_act[i]) + 1;
            end else begin
                m_tick[i] = 1'b0;
                m_due[i]  = n1 + int'(m_act[i]) + 1;
            end
        end
        if (cmt) for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
        if (w && a == 5'd17 && d[0]) m_pend = 1'b1;
        else if (cmt)                m_pend = 1'b0;
        if (w && a == 5'd18) m_sticky = (m_sticky & ~d[7:0]) | old_tick;
        else                 m_sticky = m_sticky | old_tick;
        if (w && a < 5'd8)   m_sh[a[2:0]] = d[7:0];
        if (w && a == 5'd16) m_en = d[7:0];
        edge_n = n1;
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                                 output logic [31:0] rd_seen);
        chipselect = 1'b1; write_n = !w; address = a; writedata = d;
        #1;
        rd_seen = readdata;
        checkOutput($sformatf("readdata@%0d", a), readdata, modelRead(a));
        modelEdge(w, a, d);
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        checkOutput("tick", tick, m_tick);
        checkOutput("div_out", div_out, modelDiv());
    endtask

    task automatic doReset();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset tick", tick, 0);
        checkOutput("reset div_out", div_out, 0);
        checkOutput("reset readdata", readdata, (address == 5'd19) ? 32'h808 : 32'h0);
        modelReset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] rd;
    logic [4:0]  ra;
    logic [31:0] rdat;
    logic        rw;
    int          sel;

    initial begin
        for (int a = 0; a < 20; a++)
            vecs.push_back('{1'b0, 5'(a), 32'h0, (a == 19) ? 32'h0808 : 32'h0});
        vecs.push_back('{1'b1, 5'd3,  32'h0000_00AB, 32'h0});
        vecs.push_back('{1'b0, 5'd3,  32'h0,         32'hAB});
        vecs.push_back('{1'b1, 5'd5,  32'h0000_01FF, 32'h0});
        vecs.push_back('{1'b0, 5'd5,  32'h0,         32'hFF});
        vecs.push_back('{1'b1, 5'd10, 32'h55,        32'h0});
        vecs.push_back('{1'b0, 5'd10, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 5'd19, 32'h0,         32'h808});
        vecs.push_back('{1'b0, 5'd19, 32'h0,         32'h808});
        vecs.push_back('{1'b1, 5'd17, 32'h2,         32'h0});
        vecs.push_back('{1'b0, 5'd17, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 5'd25, 32'h5,         32'h0});
        vecs.push_back('{1'b0, 5'd25, 32'h0,         32'h0});

        modelReset();
        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, rd);
            checkOutput($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
        end

        // Channel 2 at div 4: tick every 5 edges, sticky set and W1C behaviour.
        doReset();
        applyStimulus(1, 5'd2, 32'd4, rd);
        applyStimulus(1, 5'd17, 32'd1, rd);
        applyStimulus(0, 5'd17, 32'd0, rd);
        checkOutput("ch2 pending", rd, 32'd1);
        applyStimulus(1, 5'd16, 32'h04, rd);
        for (int j = 1; j <= 15; j++) begin
            applyStimulus(0, 5'd18, 32'd0, rd);
            checkOutput($sformatf("ch2 tick j%0d", j), {63'b0, tick[2]}, {63'b0, (j % 5) == 0});
        end
        applyStimulus(1, 5'd18, 32'h04, rd);
        checkOutput("sticky set", rd, 32'h04);
        applyStimulus(1, 5'd18, 32'h04, rd);
        checkOutput("sticky set wins", rd, 32'h04);
        applyStimulus(0, 5'd18, 32'd0, rd);
        checkOutput("sticky cleared", rd, 32'h0);

        // Commit aligned to channel 0's reload edge.
        doReset();
        applyStimulus(1, 5'd0, 32'd9, rd);
        applyStimulus(1, 5'd17, 32'd1, rd);
        applyStimulus(0, 5'd19, 32'd0, rd);
        applyStimulus(1, 5'd16, 32'h01, rd);
        for (int j = 0; j < 3; j++) applyStimulus(0, 5'd19, 32'd0, rd);
        applyStimulus(1, 5'd1, 32'd2, rd);
        applyStimulus(1, 5'd17, 32'd1, rd);
        for (int k = 6; k <= 10; k++) begin
            applyStimulus(0, 5'd17, 32'd0, rd);
            checkOutput($sformatf("align pending k%0d", k), rd, 32'd1);
            checkOutput($sformatf("align div1 k%0d", k), {56'b0, div_out[15:8]}, (k == 10) ? 64'd2 : 64'd0);
            checkOutput($sformatf("align tick0 k%0d", k), {63'b0, tick[0]}, {63'b0, k == 10});
        end
        applyStimulus(0, 5'd17, 32'd0, rd);
        checkOutput("align pending cleared", rd, 32'd0);

        // Channels 1 and 3, channel 0 off: commit reloads both on the next edge.
        doReset();
        applyStimulus(1, 5'd1, 32'd1, rd);
        applyStimulus(1, 5'd3, 32'd2, rd);
        applyStimulus(1, 5'd17, 32'd1, rd);
        applyStimulus(0, 5'd19, 32'd0, rd);
        applyStimulus(1, 5'd16, 32'h0A, rd);
        applyStimulus(0, 5'd19, 32'd0, rd);
        applyStimulus(1, 5'd1, 32'd3, rd);
        applyStimulus(1, 5'd3, 32'd6, rd);
        applyStimulus(1, 5'd17, 32'd1, rd);
        applyStimulus(0, 5'd19, 32'd0, rd);
        checkOutput("pair div1", {56'b0, div_out[15:8]}, 64'd3);
        checkOutput("pair div3", {56'b0, div_out[31:24]}, 64'd6);
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(0, 5'd19, 32'd0, rd);
            checkOutput($sformatf("pair tick1 j%0d", j), {63'b0, tick[1]}, {63'b0, (j == 4) || (j == 8)});
            checkOutput($sformatf("pair tick3 j%0d", j), {63'b0, tick[3]}, {63'b0, j == 7});
        end

        // div 0 ticks continuously; shadow write on the commit edge stays staged.
        doReset();
        applyStimulus(1, 5'd16, 32'h01, rd);
        for (int j = 0; j < 5; j++) begin
            applyStimulus(0, 5'd19, 32'd0, rd);
            checkOutput($sformatf("div0 tick j%0d", j), {63'b0, tick[0]}, 64'd1);
        end
        applyStimulus(1, 5'd0, 32'd3, rd);
        applyStimulus(1, 5'd17, 32'd1, rd);
        applyStimulus(1, 5'd0, 32'd5, rd);
        checkOutput("coincide active", {56'b0, div_out[7:0]}, 64'd3);
        applyStimulus(0, 5'd0, 32'd0, rd);
        checkOutput("coincide shadow", rd, 32'd5);

        // Reset mid-count with a commit pending.
        doReset();
        applyStimulus(1, 5'd0, 32'd9, rd);
        applyStimulus(1, 5'd17, 32'd1, rd);
        applyStimulus(0, 5'd19, 32'd0, rd);
        applyStimulus(1, 5'd16, 32'h05, rd);
        for (int j = 0; j < 3; j++) applyStimulus(0, 5'd19, 32'd0, rd);
        applyStimulus(1, 5'd17, 32'd1, rd);
        checkOutput("pre-reset tick2", {63'b0, tick[2]}, 64'd1);
        address = 5'd17;
        doReset();
        for (int j = 0; j < 6; j++) begin
            applyStimulus(0, 5'd17, 32'd0, rd);
            checkOutput($sformatf("post-reset tick j%0d", j), tick, 64'd0);
        end

        // Randomized traffic against the model.
        doReset();
        for (int c = 0; c < 1500; c++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: begin
                    ra = 5'($urandom_range(0, 7));
                    rdat = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
                end
                4: begin ra = 5'd16; rdat = $urandom; end
                5: begin ra = 5'd17; rdat = 32'($urandom_range(0, 1)); end
                6: begin ra = 5'd18; rdat = $urandom; end
                7: begin ra = 5'($urandom_range(0, 31)); rdat = $urandom; end
                default: begin ra = 5'($urandom_range(0, 19)); rdat = 32'h0; end
            endcase
            rw = ($urandom_range(0, 2) != 0);
            applyStimulus(rw, ra, rdat, rd);
            if (c == 700) doReset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
